// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - shared state encoding and ASCII constants for the decimal transmitter
package ascii_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CONV      = 3'd1,
    SEND_TENS = 3'd2,
    SEND_ONES = 3'd3,
    SEND_TERM = 3'd4
  } tx_state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [6:0] DEC_BASE   = 7'd10;

endpackage

// File: rtl/div10_step.sv
// rtl/div10_step.sv - one repeated-subtraction step: flags rem >= 10 and forms rem - 10
module div10_step
  import ascii_pkg::*;
(
  input  logic [6:0] rem_in,
  output logic       ge10,
  output logic [6:0] rem_out
);

  logic [7:0] sum;

  // Subtract as an add of the inverted operand with carry-in; carry-out means no borrow.
  assign sum     = {1'b0, rem_in} + {1'b0, ~DEC_BASE} + 8'd1;
  assign ge10    = sum[7];
  assign rem_out = sum[6:0];

endmodule

// File: rtl/sum_ascii_tx.sv
// rtl/sum_ascii_tx.sv - sends an adder result as two ASCII decimal digits plus a terminator
module sum_ascii_tx
  import ascii_pkg::*;
#(
  parameter int         WIDTH     = 6,
  parameter logic [7:0] TERM_CHAR = ASCII_LF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  tx_state_t  state, state_nxt;
  logic [6:0] rem, rem_nxt, rem_sub;
  logic [2:0] tens, tens_nxt;
  logic       ge10;
  logic       out_valid_nxt;
  logic [7:0] out_data_nxt;

  div10_step u_div10_step (
    .rem_in  (rem),
    .ge10    (ge10),
    .rem_out (rem_sub)
  );

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= 7'd0;
      tens      <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      tens      <= tens_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    tens_nxt      = tens;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    case (state)
      IDLE: begin
        if (in_valid) begin
          rem_nxt   = {{(7-WIDTH){1'b0}}, in_value};
          tens_nxt  = 3'd0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (ge10) begin
          rem_nxt  = rem_sub;
          tens_nxt = tens + 3'd1;
        end else begin
          // Tens digit is final once the remainder drops below ten.
          out_data_nxt  = ASCII_ZERO + {5'b0, tens};
          out_valid_nxt = 1'b1;
          state_nxt     = SEND_TENS;
        end
      end
      SEND_TENS: begin
        if (out_ready) begin
          out_data_nxt = ASCII_ZERO + {1'b0, rem};
          state_nxt    = SEND_ONES;
        end
      end
      SEND_ONES: begin
        if (out_ready) begin
          out_data_nxt = TERM_CHAR;
          state_nxt    = SEND_TERM;
        end
      end
      SEND_TERM: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sum_ascii_tx.sv
// tb/tb_sum_ascii_tx.sv - directed self-checking bench for sum_ascii_tx
module tb_sum_ascii_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_value = 6'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;

  int total = 0;
  int bad = 0;
  logic [7:0] rx_q[$];

  sum_ascii_tx #(.WIDTH(6), .TERM_CHAR(8'h0A)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) rx_q.push_back(out_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hFF;
  endfunction

  task automatic wait_bytes(input int n, output logic busy_all);
    busy_all = 1'b1;
    for (int i = 0; i < 60 && rx_q.size() < n; i++) begin
      @(negedge clk); #1;
      if (!busy) busy_all = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
  endtask

  task automatic xfer(input string tag, input logic [5:0] v,
                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int exp_lat, input int exp_conv, input bit chk_busy);
    int lat, conv;
    logic busy_all, conv_busy;
    rx_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_value = v;
    @(negedge clk);
    for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    conv = 0;
    conv_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
      conv++;
      if (!busy) conv_busy = 1'b0;
      @(posedge clk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_conv"}, conv, exp_conv);
    wait_bytes(3, busy_all);
    check({tag, "_b0"}, rx_at(0), b0);
    check({tag, "_b1"}, rx_at(1), b1);
    check({tag, "_b2"}, rx_at(2), b2);
    if (chk_busy) check({tag, "_busy"}, {31'd0, busy_all & conv_busy}, 32'd1);
    wait_idle();
    check({tag, "_cnt"}, rx_q.size(), 3);
  endtask

  initial begin
    logic busy_all;
    int term_seen;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    xfer("t1_15", 6'd15, 8'h31, 8'h35, 8'h0A, 3, 2, 1'b0);
    xfer("t2_0", 6'd0, 8'h30, 8'h30, 8'h0A, 2, 1, 1'b0);
    xfer("t3_63", 6'd63, 8'h36, 8'h33, 8'h0A, 8, 7, 1'b1);

    // back-pressure in SEND_ONES with ignored in_valid pulses
    rx_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_value = 6'd25;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !(out_valid && out_ready); i++) @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_value = 6'd12;
      @(negedge clk);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_data", out_data, 8'h35);
      check("t4_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_bytes(3, busy_all);
    wait_idle();
    repeat (10) @(negedge clk);
    check("t4_cnt", rx_q.size(), 3);
    check("t4_b0", rx_at(0), 8'h32);
    check("t4_b1", rx_at(1), 8'h35);
    check("t4_b2", rx_at(2), 8'h0A);

    // reset while the tens digit is pending
    rx_q.delete();
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_value = 6'd42;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    check("t5_tens_pending", out_data, 8'h34);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5_out_valid", out_valid, 0);
    check("t5_in_ready", in_ready, 1);
    check("t5_busy", busy, 0);
    out_ready = 1'b1;
    xfer("t5_9", 6'd9, 8'h30, 8'h39, 8'h0A, 2, 1, 1'b0);

    // in_valid held across two values
    rx_q.delete();
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_value = 6'd10;
    @(posedge clk); #1;
    in_value = 6'd27;
    term_seen = 0;
    for (int i = 0; i < 60 && term_seen == 0; i++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_data == 8'h0A) begin
        term_seen = 1;
        check("t6_ready_at_term", in_ready, 0);
        @(negedge clk);
        check("t6_ready_after_term", in_ready, 1);
      end
    end
    check("t6_term_seen", term_seen, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_bytes(6, busy_all);
    wait_idle();
    check("t6_cnt", rx_q.size(), 6);
    check("t6_b0", rx_at(0), 8'h31);
    check("t6_b1", rx_at(1), 8'h30);
    check("t6_b2", rx_at(2), 8'h0A);
    check("t6_b3", rx_at(3), 8'h32);
    check("t6_b4", rx_at(4), 8'h37);
    check("t6_b5", rx_at(5), 8'h0A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
